// File: rtl/mux48_6in_seq.sv
`default_nettype none
// mux48_6in_seq: steps the select of the 6-input 48-bit mux through a channel mask and
// tags the mux output word with valid/index/last, delayed to match the mux pipeline.
module mux48_6in_seq #(
   parameter int NIN     = 6,
   parameter int SELW    = 3,
   parameter int LATENCY = 2
) (
   input  logic            clock_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic [NIN-1:0]  mask_i,
   input  logic            hold_i,
   output logic [SELW-1:0] sel_o,
   output logic            out_valid_o,
   output logic [SELW-1:0] out_idx_o,
   output logic            out_last_o,
   output logic            busy_o,
   output logic            done_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [NIN-1:0]  rem_q, rem_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic            iss_v_q, iss_v_d;
   logic [SELW-1:0] iss_idx_q, iss_idx_d;
   logic            iss_last_q, iss_last_d;
   logic            zdone_q, zdone_d;

   logic [LATENCY-1:0] pv_q;
   logic [LATENCY-1:0] pl_q;
   logic [SELW-1:0]    pidx_q [LATENCY];

   logic [NIN-1:0]  src;
   logic [NIN-1:0]  low_onehot;
   logic [NIN-1:0]  rest;
   logic [SELW-1:0] low_idx;
   logic            do_issue;
   logic            drain_end;

   function automatic logic [SELW-1:0] f_lowest(input logic [NIN-1:0] v);
      logic [SELW-1:0] r;
      r = '0;
      for (int i = NIN - 1; i >= 0; i--) begin
         if (v[i]) r = SELW'(i);
      end
      return r;
   endfunction

   // The first channel is issued on the start edge itself, straight from the mask.
   assign src        = (state_q == ST_IDLE) ? mask_i : rem_q;
   assign low_onehot = src & (~src + NIN'(1));
   assign rest       = src & ~low_onehot;
   assign low_idx    = f_lowest(src);
   assign do_issue   = ((state_q == ST_IDLE) && start_i && (mask_i != '0)) ||
                       ((state_q == ST_ISSUE) && !hold_i);
   assign drain_end  = (state_q == ST_DRAIN) && pv_q[LATENCY-1] && pl_q[LATENCY-1];

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      sel_d      = sel_q;
      iss_v_d    = 1'b0;
      iss_idx_d  = '0;
      iss_last_d = 1'b0;
      zdone_d    = (state_q == ST_IDLE) && start_i && (mask_i == '0);

      if (do_issue) begin
         sel_d      = low_idx;
         iss_v_d    = 1'b1;
         iss_idx_d  = low_idx;
         iss_last_d = (rest == '0);
         rem_d      = rest;
         state_d    = (rest == '0) ? ST_DRAIN : ST_ISSUE;
      end else if (drain_end) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         rem_q      <= '0;
         sel_q      <= '0;
         iss_v_q    <= 1'b0;
         iss_idx_q  <= '0;
         iss_last_q <= 1'b0;
         zdone_q    <= 1'b0;
         pv_q       <= '0;
         pl_q       <= '0;
         for (int k = 0; k < LATENCY; k++) pidx_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         sel_q      <= sel_d;
         iss_v_q    <= iss_v_d;
         iss_idx_q  <= iss_idx_d;
         iss_last_q <= iss_last_d;
         zdone_q    <= zdone_d;
         // Tag pipeline free-runs so hold bubbles stay cycle-aligned with the mux.
         pv_q[0]    <= iss_v_q;
         pl_q[0]    <= iss_last_q;
         pidx_q[0]  <= iss_idx_q;
         for (int k = 1; k < LATENCY; k++) begin
            pv_q[k]   <= pv_q[k-1];
            pl_q[k]   <= pl_q[k-1];
            pidx_q[k] <= pidx_q[k-1];
         end
      end
   end

   assign sel_o       = sel_q;
   assign out_valid_o = pv_q[LATENCY-1];
   assign out_idx_o   = pidx_q[LATENCY-1];
   assign out_last_o  = pl_q[LATENCY-1];
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = zdone_q | drain_end;

endmodule
`default_nettype wire

// File: tb/tb_mux48_6in_seq.sv
`default_nettype none
// tb_mux48_6in_seq: directed test-plan sequences plus random traffic, checked every cycle
// against a cycle-scheduled event model and a behavioural 2-stage 48-bit mux.
module tb_mux48_6in_seq;

   localparam int LAT = 2;

   logic        clk;
   logic        rst;
   logic        start;
   logic [5:0]  mask;
   logic        hold;
   logic [2:0]  sel;
   logic        out_valid;
   logic [2:0]  out_idx;
   logic        out_last;
   logic        busy;
   logic        done;

   mux48_6in_seq #(.NIN(6), .SELW(3), .LATENCY(LAT)) dut (
      .clock_i     (clk),
      .reset_i     (rst),
      .start_i     (start),
      .mask_i      (mask),
      .hold_i      (hold),
      .sel_o       (sel),
      .out_valid_o (out_valid),
      .out_idx_o   (out_idx),
      .out_last_o  (out_last),
      .busy_o      (busy),
      .done_o      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Behavioural mux: input register then P register, words tagged by channel number.
   logic [47:0] mux_r1, mux_out;
   always @(posedge clk) begin
      mux_r1  <= 48'hA00000000000 | 48'(sel);
      mux_out <= mux_r1;
   end

   // Reference model: outputs are scheduled by absolute cycle number.
   int       q_ch[$];
   bit       m_inseq = 1'b0;
   int       last_cyc = 0;
   logic [2:0] m_sel = 3'd0;
   bit       ev_v[int];
   int       ev_i[int];
   bit       ev_l[int];
   bit       ev_d[int];
   logic [2:0] exp_sel, exp_idx;
   bit       exp_v, exp_l, exp_d, exp_busy;
   int       n;

   task automatic issue(input int c);
      m_sel = 3'(q_ch.pop_front());
      ev_v[c+LAT] = 1'b1;
      ev_i[c+LAT] = int'(m_sel);
      ev_l[c+LAT] = (q_ch.size() == 0);
      if (q_ch.size() == 0) begin
         last_cyc    = c + LAT;
         ev_d[c+LAT] = 1'b1;
      end
   endtask

   always @(posedge clk) begin
      n = cyc;
      if (rst) begin
         q_ch.delete();
         m_inseq = 1'b0;
         m_sel   = 3'd0;
         ev_v.delete(); ev_i.delete(); ev_l.delete(); ev_d.delete();
         chk_en  = 1'b1;
      end else begin
         if (!m_inseq) begin
            if (start) begin
               if (mask != 6'd0) begin
                  for (int i = 0; i < 6; i++) if (mask[i]) q_ch.push_back(i);
                  m_inseq = 1'b1;
                  issue(n + 1);
               end else begin
                  ev_d[n+1] = 1'b1;
               end
            end
         end else if (q_ch.size() != 0 && !hold) begin
            issue(n + 1);
         end
         if (m_inseq && q_ch.size() == 0 && (n + 1) > last_cyc) m_inseq = 1'b0;
      end
      cyc      = n + 1;
      exp_sel  = m_sel;
      exp_busy = m_inseq;
      exp_v    = ev_v.exists(cyc);
      exp_idx  = exp_v ? 3'(ev_i[cyc]) : 3'd0;
      exp_l    = exp_v ? ev_l[cyc] : 1'b0;
      exp_d    = ev_d.exists(cyc);
      if (ev_v.exists(cyc)) begin ev_v.delete(cyc); ev_i.delete(cyc); ev_l.delete(cyc); end
      if (ev_d.exists(cyc)) ev_d.delete(cyc);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_val("sel",       64'(sel),       64'(exp_sel));
         check_val("out_valid", 64'(out_valid), 64'(exp_v));
         check_val("out_idx",   64'(out_idx),   64'(exp_idx));
         check_val("out_last",  64'(out_last),  64'(exp_l));
         check_val("busy",      64'(busy),      64'(exp_busy));
         check_val("done",      64'(done),      64'(exp_d));
         if (exp_v) check_val("mux_word", 64'(mux_out), 64'(48'hA00000000000 | 48'(exp_idx)));
      end
   end

   task automatic step(input bit s, input logic [5:0] m, input bit h, input bit r);
      start = s;
      mask  = m;
      hold  = h;
      rst   = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(1'b0, 6'd0, 1'b0, 1'b0);
   endtask

   initial begin
      start = 1'b0; mask = 6'd0; hold = 1'b0; rst = 1'b1;
      step(0, 6'd0, 0, 1);
      step(0, 6'd0, 0, 1);
      idle(2);
      // Full mask, no hold
      step(1, 6'b111111, 0, 0);
      idle(10);
      // Sparse mask
      step(1, 6'b100101, 0, 0);
      idle(6);
      // Full mask with two hold cycles at t+2..t+3
      step(1, 6'b111111, 0, 0);
      step(0, 6'd0, 0, 0);
      step(0, 6'd0, 1, 0);
      step(0, 6'd0, 1, 0);
      idle(10);
      // Empty mask, then a single-channel mask
      step(1, 6'd0, 0, 0);
      idle(2);
      step(1, 6'b000010, 0, 0);
      idle(5);
      // Start ignored during ISSUE and DRAIN, accepted right after done
      step(1, 6'b111111, 0, 0);
      step(0, 6'd0, 0, 0);
      step(1, 6'b001010, 0, 0);
      idle(4);
      step(1, 6'b010000, 1, 0);
      step(0, 6'd0, 0, 0);
      step(1, 6'b000111, 0, 0);
      idle(8);
      // Reset while the third word is in the tag pipeline
      step(1, 6'b111111, 0, 0);
      idle(3);
      step(0, 6'd0, 0, 1);
      idle(10);
      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 7) == 0), 6'($urandom), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 99) == 0));
      end
      idle(10);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux48_6in_seq.md
Name: mux48_6in_seq

Overview:
- Sequencer that drives the select of the 6-input 48-bit DSP mux and tags the mux output with valid, index and last.
- On a start pulse it steps sel through every channel enabled in a mask, lowest index first, one channel per cycle.
- Hold inserts bubbles. Tags are delayed by the mux pipeline latency so they align cycle-exactly with the mux out word.
- Sits directly upstream of the mux (sel) and beside its output (tags) for the downstream consumer.

Parameters:
- NIN, 6, number of mux channels.
- SELW, 3, select width; must satisfy 2^SELW >= NIN.
- LATENCY, 2, cycles from a sel value at the mux input to the corresponding word at the mux out port (input/opmode register + P register).

Ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  1-cycle request; sampled only in IDLE.
- mask  input  NIN  channels to read; bit i enables channel i; sampled with start.
- hold  input  1  while high the sequencer does not advance; a bubble is issued.
- sel  output  SELW  registered select to the mux.
- out_valid  output  1  mux out word this cycle belongs to the sequence.
- out_idx  output  SELW  channel index of the current mux out word.
- out_last  output  1  current word is the final word of the sequence.
- busy  output  1  sequence in progress, including pipeline drain.
- done  output  1  1-cycle pulse at end of sequence.

Behaviour:
- Reset values: sel=0, out_valid=0, out_idx=0, out_last=0, busy=0, done=0, pipeline tags cleared, FSM=IDLE.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 and mask!=0 -> copy mask to rem, busy=1, go ISSUE.
  - start=1 and mask==0 -> done pulses next cycle, busy stays 0, no out_valid, stay IDLE.
  - start=0 -> stay IDLE.
- ISSUE, each cycle:
  - hold=0: sel<=index of lowest set bit of rem; issue tag (valid=1, idx, last=(rem has one bit)); clear that bit in rem.
  - Issuing the final bit -> go DRAIN.
  - hold=1: sel keeps its value, a tag with valid=0 is pushed, rem unchanged.
- Tag pipeline: LATENCY-deep shift register; advances every cycle regardless of hold. A tag issued with sel in cycle c appears on out_valid/out_idx/out_last in cycle c+LATENCY.
- DRAIN: waits until the last tag reaches the output. In that cycle out_last=1 and done=1. Next cycle busy=0, go IDLE.
- First sel is presented in the cycle after start is sampled. First out_valid follows LATENCY cycles later.
- Throughput: one word per cycle. No gaps except hold cycles.
- sel is held at its last value in IDLE and DRAIN.
- start while busy (ISSUE or DRAIN) is ignored; it is not queued.
- A new start is accepted in the cycle after done (back-to-back sequences).
- hold in IDLE or DRAIN has no effect.
- Mask bits are only sampled at start; later mask changes are ignored.
- Reset mid-operation: all state, rem and in-flight tags cleared next edge. No out_valid or done follows from the aborted sequence.
- out_idx/out_last are 0 whenever out_valid=0.

Test Plan:
1. reset, then start with mask=6'b111111, hold=0:
   - sel=0..5 on cycles t+1..t+6.
   - out_valid on t+3..t+8 with out_idx 0..5.
   - out_last and done at t+8; busy falls at t+9.
2. mask=6'b100101:
   - sel sequence 0,2,5 on three consecutive cycles.
   - out_idx 0,2,5 with LATENCY=2 alignment; out_last with idx 5.
   - Feed in_i=48'hA0000000000i and check mux out equals the tagged channel's word.
3. mask=6'b111111 with hold=1 on cycles t+2..t+3:
   - sel stays 1 during the hold.
   - Two out_valid=0 bubbles appear at t+5..t+6.
   - Sequence completes with 6 valid words; done at t+10.
4. start with mask=0:
   - done pulses one cycle later.
   - busy, out_valid and sel unchanged.
   - Second start with mask=6'b000010 in the same test yields a single word idx=1 with out_last=1.
5. start pulse during ISSUE with a different mask:
   - Ignored; original sequence completes unchanged.
   - start in the cycle after done is accepted.
6. reset asserted while the 3rd word is in the tag pipeline:
   - Next cycle all outputs are at reset values.
   - No out_valid or done appear afterwards until a new start.
